// File: rtl/instr_fetch.sv
// instr_fetch -- RV32I instruction-fetch controller.
//
// Takes the current PC, runs a req/ack read against instruction memory and
// latches the returned word into the instruction register. A one-cycle
// pc_inc pulse (coincident with instr_valid) advances the PC once per
// completed fetch. Branch flushes, misaligned PCs and memory timeouts are
// handled here.
//
// Ports:
//   clk, clr            clock; asynchronous active-high reset
//   fetch_en, stall     start a fetch from IDLE unless stalled
//   flush               discard the in-flight result / clear a fault
//   pc_val              fetch address from the PC
//   mem_req, mem_addr   read request to memory (addr stable while req=1)
//   mem_ack, mem_rdata  memory response
//   instr, instr_valid  instruction register and its one-cycle valid pulse
//   pc_inc              one-cycle PC-advance pulse
//   busy                any state other than IDLE (PC disable)
//   fault               sticky misaligned-PC / timeout flag
module instr_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              pc_inc,
    output logic              busy,
    output logic              fault
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_DONE    = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    // Wait cycles are counted from 0; the request gives up on the cycle the
    // counter sits at TIMEOUT-1, so mem_req is high for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                req_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   instr_d;
    logic                vld_d;
    logic                busy_d;
    logic                fault_d;
    logic [7:0]          cnt_q, cnt_d;
    // Set when a flush lands while the read is still outstanding; the
    // memory cannot be aborted, so the late data is thrown away instead.
    logic                drop_q, drop_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_inc      <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req     <= req_d;
            mem_addr    <= addr_d;
            instr       <= instr_d;
            instr_valid <= vld_d;
            pc_inc      <= vld_d;
            busy        <= busy_d;
            fault       <= fault_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = mem_req;
        addr_d  = mem_addr;
        instr_d = instr;
        vld_d   = 1'b0;
        fault_d = fault;
        cnt_d   = cnt_q;
        drop_d  = drop_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && !stall) begin
                    if (pc_val[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        addr_d  = pc_val;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        state_d = S_REQUEST;
                    end
                end
            end
            S_REQUEST: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!drop_q && !flush) begin
                        instr_d = mem_rdata;
                        vld_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (flush) drop_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (flush) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
